// File: rtl/hdmuxn_rr.sv
// hdmuxn_rr: N-channel to 1 registered mux with ready/valid handshakes.
// MODE=0 arbitrates round-robin from a rotating pointer; MODE=1 grants only the channel named by
// SL. One output register stage, so a granted beat appears on Z one cycle after its transfer.
module hdmuxn_rr #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SW    = $clog2(NCH)
) (
   input  logic                 CK,
   input  logic                 RN,
   input  logic [NCH-1:0]       IN_VALID,
   input  logic [NCH*WIDTH-1:0] IN_DATA,
   output logic [NCH-1:0]       IN_READY,
   input  logic                 MODE,
   input  logic [SW-1:0]        SL,
   output logic [WIDTH-1:0]     Z,
   output logic [SW-1:0]        Z_CH,
   output logic                 Z_VALID,
   input  logic                 Z_READY
);

   // Pointer width only needs to span the channel count; SW may be wider.
   localparam int unsigned PW = $clog2(NCH);
   localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

   logic [WIDTH-1:0] z_q, z_d;
   logic [SW-1:0]    z_ch_q, z_ch_d;
   logic             z_valid_q, z_valid_d;
   logic [PW-1:0]    ptr_q, ptr_d;

   logic             load_en;
   logic [2*NCH-1:0] vld_dbl;
   logic [NCH-1:0]   vld_rot;
   logic [PW-1:0]    rr_off;
   logic [PW:0]      rr_sum;
   logic [PW-1:0]    rr_idx;
   logic [PW:0]      ptr_inc;
   logic             rr_any;
   logic [NCH-1:0]   gnt_vec;
   logic [SW-1:0]    gnt_idx;
   logic [WIDTH-1:0] gnt_data;
   logic             xfer;

   assign load_en = !z_valid_q || Z_READY;

   // Round-robin search: rotate valids so the pointer channel sits at bit 0, take the lowest set
   // bit, then map the offset back to an absolute channel index.
   always_comb begin
      vld_dbl = {IN_VALID, IN_VALID} >> ptr_q;
      vld_rot = vld_dbl[NCH-1:0];
      rr_any  = |vld_rot;
      rr_off  = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (vld_rot[k]) rr_off = PW'(k);
      end
      rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
      if (rr_sum >= NCH_W) rr_sum = rr_sum - NCH_W;
      rr_idx = rr_sum[PW-1:0];
   end

   // Grant selection for both modes; an out-of-range SL matches no channel and grants nothing.
   always_comb begin
      gnt_vec = '0;
      gnt_idx = '0;
      if (MODE) begin
         for (int i = 0; i < NCH; i++) begin
            if (SL == SW'(i)) gnt_vec[i] = IN_VALID[i];
         end
         gnt_idx = SL;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (rr_any && (rr_idx == PW'(i))) gnt_vec[i] = 1'b1;
         end
         gnt_idx = SW'(rr_idx);
      end
   end

   // Handshake and data steering; ready is held low during reset and while the output stalls.
   always_comb begin
      IN_READY = (RN && load_en) ? gnt_vec : '0;
      xfer     = |IN_READY;
      gnt_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_vec[i]) gnt_data = IN_DATA[i*WIDTH +: WIDTH];
      end
   end

   // Next-state for the output beat and the round-robin pointer.
   always_comb begin
      z_d       = z_q;
      z_ch_d    = z_ch_q;
      z_valid_d = z_valid_q;
      ptr_d     = ptr_q;
      ptr_inc   = {1'b0, rr_idx} + 1'b1;
      if (ptr_inc >= NCH_W) ptr_inc = '0;
      if (xfer) begin
         z_d       = gnt_data;
         z_ch_d    = gnt_idx;
         z_valid_d = 1'b1;
         if (!MODE) ptr_d = ptr_inc[PW-1:0];
      end else if (Z_READY) begin
         z_valid_d = 1'b0;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         z_q       <= '0;
         z_ch_q    <= '0;
         z_valid_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         z_q       <= z_d;
         z_ch_q    <= z_ch_d;
         z_valid_q <= z_valid_d;
         ptr_q     <= ptr_d;
      end
   end

   assign Z       = z_q;
   assign Z_CH    = z_ch_q;
   assign Z_VALID = z_valid_q;

endmodule

// File: tb/tb_hdmuxn_rr.sv
// Directed plus random bench for hdmuxn_rr; loaded beats go into a scoreboard queue and are
// compared against Z/Z_CH while Z_VALID is high.
module tb_hdmuxn_rr;

   logic        ck, rn;
   logic [3:0]  in_valid, in_ready;
   logic [31:0] in_data;
   logic        mode;
   logic [2:0]  sl;
   logic [7:0]  z;
   logic [2:0]  z_ch;
   logic        z_valid, z_ready;

   int n_pass = 0;
   int n_total = 0;

   // Reference state.
   int          ptr_m;
   logic        mv;
   logic [10:0] sbq[$];

   hdmuxn_rr #(.WIDTH(8), .NCH(4), .SW(3)) dut (
      .CK       (ck),
      .RN       (rn),
      .IN_VALID (in_valid),
      .IN_DATA  (in_data),
      .IN_READY (in_ready),
      .MODE     (mode),
      .SL       (sl),
      .Z        (z),
      .Z_CH     (z_ch),
      .Z_VALID  (z_valid),
      .Z_READY  (z_ready)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   initial begin
      #200000;
      $display("FAIL watchdog: obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int m_grant();
      int j;
      if (mode) begin
         if (int'(sl) < 4 && ((in_valid >> sl) & 4'd1) != 4'd0) return int'(sl);
         return -1;
      end
      for (int k = 0; k < 4; k++) begin
         j = (ptr_m + k) % 4;
         if (((in_valid >> j) & 4'd1) != 4'd0) return j;
      end
      return -1;
   endfunction

   // One clock: check ready, advance the model, then compare the output beat on the falling edge.
   task automatic step();
      int          g;
      logic        le;
      logic [3:0]  exp_rdy;
      logic [10:0] beat;
      #1;
      g       = m_grant();
      le      = !mv || z_ready;
      exp_rdy = (le && g >= 0) ? 4'(1 << g) : 4'b0;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (mv && z_ready && sbq.size() > 0) beat = sbq.pop_front();
      if (le && g >= 0) begin
         sbq.push_back({3'(g), 8'(in_data >> (g * 8))});
         if (!mode) ptr_m = (g + 1) % 4;
         mv = 1'b1;
      end else if (z_ready) begin
         mv = 1'b0;
      end
      @(posedge ck);
      @(negedge ck);
      chk("z_valid", 64'(z_valid), 64'(mv));
      if (mv) begin
         if (sbq.size() == 0) begin
            chk("scoreboard_empty", 64'(sbq.size()), 64'd1);
         end else begin
            chk("z_ch", 64'(z_ch), 64'(sbq[0][10:8]));
            chk("z", 64'(z), 64'(sbq[0][7:0]));
         end
      end
   endtask

   initial begin
      rn = 1'b0; in_valid = 4'b1111; in_data = 32'h44332211;
      mode = 1'b0; sl = 3'd0; z_ready = 1'b1;
      ptr_m = 0; mv = 1'b0;

      // Reset state.
      #3;
      chk("rst_z", 64'(z), 64'd0);
      chk("rst_z_ch", 64'(z_ch), 64'd0);
      chk("rst_z_valid", 64'(z_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge ck);
      rn = 1'b1;

      // Round-robin with all channels requesting: 0,1,2,3,0 back to back.
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h40302010 + 32'(i);
         step();
         chk("rr_seq", 64'(z_ch), 64'(i % 4));
         chk("rr_valid", 64'(z_valid), 64'd1);
      end

      // Mode switch with pointer at 1: three fixed beats from ch3, then round-robin resumes at 1.
      mode = 1'b1; sl = 3'd3;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h9C8C7C6C + 32'(i << 24);
         step();
         chk("fix_ch3", 64'(z_ch), 64'd3);
      end
      mode = 1'b0;
      step();
      chk("mode_back_rr", 64'(z_ch), 64'd1);

      // Fixed select SL=2 with ch2 = A5, then SL out of range drains the held beat.
      mode = 1'b1; sl = 3'd2; in_data = 32'h12A53456;
      #1;
      chk("fix_ready_only2", 64'(in_ready), 64'b0100);
      step();
      chk("fix_z_a5", 64'(z), 64'hA5);
      chk("fix_z_ch2", 64'(z_ch), 64'd2);
      sl = 3'd5;
      step();
      chk("sl_oor_drain", 64'(z_valid), 64'd0);

      // Sparse requests: reach pointer 3, then 0100 wraps to ch2, then 1001 gives ch3.
      mode = 1'b0; in_valid = 4'b0100;
      step();
      step();
      chk("sparse_ch2", 64'(z_ch), 64'd2);
      in_valid = 4'b1001;
      step();
      chk("sparse_ch3", 64'(z_ch), 64'd3);

      // Backpressure: hold 3C for five stalled cycles while inputs toggle.
      in_valid = 4'b0001; in_data = 32'h5566773C;
      step();
      chk("bp_load_3c", 64'(z), 64'h3C);
      z_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 4'($urandom_range(0, 15));
         in_data  = $urandom;
         mode     = 1'($urandom_range(0, 1));
         sl       = 3'($urandom_range(0, 7));
         step();
         chk("bp_hold_3c", 64'(z), 64'h3C);
      end
      mode = 1'b0; z_ready = 1'b1; in_valid = 4'b1111;
      step();
      chk("bp_release_ch1", 64'(z_ch), 64'd1);

      // Reset between edges with a held beat and pointer at 2.
      #2;
      rn = 1'b0;
      #1;
      chk("mid_rst_z_valid", 64'(z_valid), 64'd0);
      chk("mid_rst_z", 64'(z), 64'd0);
      chk("mid_rst_z_ch", 64'(z_ch), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      sbq.delete(); mv = 1'b0; ptr_m = 0;
      @(negedge ck);
      rn = 1'b1;
      step();
      chk("post_rst_ch0", 64'(z_ch), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         in_valid = 4'($urandom_range(0, 15));
         in_data  = $urandom;
         mode     = ($urandom_range(0, 3) == 0);
         sl       = 3'($urandom_range(0, 7));
         z_ready  = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hdmuxn_rr.md
HDMUXN_RR -- requirements
Module: hdmuxn_rr

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel, legal range 1..64.
REQ-002 Parameter NCH, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter SW, default $clog2(NCH): width of the select and channel-ID fields.
REQ-004 Port CK, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port RN, input, 1: asynchronous, active-low reset; assertion clears state immediately, deassertion is synchronous to CK.
REQ-006 Port IN_VALID, input, NCH: bit i high means channel i offers data.
REQ-007 Port IN_DATA, input, NCH*WIDTH: channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port IN_READY, output, NCH: bit i high means channel i's data is accepted this cycle.
REQ-009 Port MODE, input, 1: 0 selects round-robin arbitration; 1 selects fixed select.
REQ-010 Port SL, input, SW: channel index used when MODE=1.
REQ-011 Port Z, output, WIDTH: registered output data.
REQ-012 Port Z_CH, output, SW: index of the channel that supplied Z.
REQ-013 Port Z_VALID, output, 1: Z and Z_CH hold an untransferred beat.
REQ-014 Port Z_READY, input, 1: downstream accepts; a beat transfers when Z_VALID and Z_READY are both high.

Function
REQ-015 A transfer on channel i SHALL occur when IN_VALID[i] and IN_READY[i] are both high at a CK edge.
REQ-016 The load enable SHALL be the term (!Z_VALID || Z_READY).
REQ-017 At most one IN_READY bit SHALL be high in any cycle, and that bit SHALL only be high when the load enable is high.
REQ-018 IN_READY SHALL be combinational from IN_VALID, MODE, SL, the pointer, Z_VALID and Z_READY; it SHALL NOT depend on IN_DATA.
REQ-019 In MODE=1, the granted channel SHALL be SL when IN_VALID[SL]=1; otherwise no channel is granted.
REQ-020 In MODE=1 with SL>=NCH, no channel SHALL be granted.
REQ-021 In MODE=0, the granted channel SHALL be the first channel with valid high, scanning upward from the pointer PTR and wrapping from NCH-1 to 0.
REQ-022 On every input transfer in MODE=0, PTR SHALL become (granted+1) mod NCH; PTR SHALL be unchanged in any other cycle.
REQ-023 PTR SHALL NOT change in MODE=1.
REQ-024 PTR SHALL be retained across MODE switches.
REQ-025 On an input transfer, Z, Z_CH and Z_VALID SHALL update at that CK edge to the granted data, the granted index and 1 respectively, giving one cycle of latency.
REQ-026 When the output is consumed and no channel is granted, Z_VALID SHALL go to 0, and Z and Z_CH SHALL hold their values.
REQ-027 While Z_VALID=1 and Z_READY=0, Z, Z_CH and Z_VALID SHALL be stable and all IN_READY bits SHALL be 0.
REQ-028 A simultaneous output consume and new input load SHALL sustain one beat per cycle with no bubble.
REQ-029 A change of MODE or SL SHALL affect only the next arbitration and SHALL NOT alter a held output beat.

Reset
REQ-030 While RN=0, the block SHALL force Z=0, Z_CH=0, Z_VALID=0 and PTR=0.
REQ-031 While RN=0, all IN_READY bits SHALL be 0.
REQ-032 Assertion of RN mid-transfer SHALL discard the held beat, with no partial update visible after reset.
REQ-033 The first grant after RN deasserts SHALL be possible at the first CK edge.

Verification
REQ-034 Scenario, round-robin: NCH=4, MODE=0, IN_VALID=4'b1111, Z_READY=1 held -> Z_CH sequence 0,1,2,3,0 on consecutive cycles, Z_VALID=1 continuously.
REQ-035 Scenario, fixed select: MODE=1, SL=2, IN_VALID=4'b1111, IN_DATA ch2=8'hA5 -> only IN_READY[2]=1, next cycle Z=8'hA5 and Z_CH=2; with SL=5 and NCH=4 -> IN_READY=0 and Z_VALID falls to 0 after the held beat drains.
REQ-036 Scenario, backpressure: Z_VALID=1 with Z=8'h3C and Z_READY=0 for 5 cycles while inputs toggle -> Z holds 8'h3C, IN_READY=0 throughout; the first cycle with Z_READY=1 loads the next beat.
REQ-037 Scenario, sparse requests: PTR=3, IN_VALID=4'b0100 -> channel 2 granted, then PTR=3 (wrap from (2+1)); next with IN_VALID=4'b1001 -> channel 3 granted, then PTR=0.
REQ-038 Scenario, reset mid-operation: Z_VALID=1, PTR=2, then RN pulsed low between edges -> Z_VALID=0, Z=0 and IN_READY=0 immediately; after release with IN_VALID=4'b1111, channel 0 is granted first.
REQ-039 Scenario, mode switch: in MODE=0 with PTR=1, switch to MODE=1 with SL=3 for 3 beats, then back to MODE=0 -> next round-robin grant is channel 1.
